rr_mux_arbiter: RTL and testbench

Parametrised N-channel, W-bit multiplexer with a registered output. It is the sequential successor to the combinational 4-to-1 mux family. The select input is replaced by internal arbitration, either round-robin or fixed priority, among requesting channels. It has valid/ready handshakes on every input and on the output. It sits between several producer blocks and one shared consumer.

---
 rtl/rr_mux_arbiter.sv | 51 +++++
 tb/tb_rr_mux_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: N-channel valid/ready mux with round-robin or fixed-priority arbitration and a registered output
module rr_mux_arbiter #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int MODE = 0,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  input  logic                     out_ready
);
  logic [SEL_W-1:0] rr_ptr, gnt_idx, cand;
  logic             gnt_vld, load_en;
  assign load_en = !out_valid || out_ready;
  // search from the highest offset down so the first requester after the start point wins
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = SEL_W'((MODE != 0) ? i : (int'(rr_ptr) + i) % NUM_CH);
      if (in_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt_vld = gnt_vld && load_en && rst_n;
  end
  assign in_ready = gnt_vld ? ({{(NUM_CH-1){1'b0}}, 1'b1} << gnt_idx) : '0;
  // load the granted word (possibly while draining the old one) and advance the round-robin pointer past the winner
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
      rr_ptr <= '0;
    end else if (gnt_vld) begin
      out_valid <= 1'b1;
      out_data <= in_data[gnt_idx*DATA_W +: DATA_W];
      out_sel <= gnt_idx;
      if (MODE == 0) rr_ptr <= (gnt_idx == SEL_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed checks of reset, round-robin, backpressure, fixed priority and non-power-of-two wrap
module tb_rr_mux_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic [3:0]  iv0 = '0, ir0, iv1 = '0, ir1;
  logic [31:0] id0 = '0, id1 = '0;
  logic        ov0, or0 = 1'b0, ov1, or1 = 1'b0, ov2, or2 = 1'b0;
  logic [7:0]  od0, od1, od2;
  logic [1:0]  os0, os1, os2;
  logic [2:0]  iv2 = '0, ir2;
  logic [23:0] id2 = '0;
  rr_mux_arbiter #(.NUM_CH(4), .DATA_W(8), .MODE(0)) d0 (.clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_data(id0),
    .in_ready(ir0), .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(or0));
  rr_mux_arbiter #(.NUM_CH(4), .DATA_W(8), .MODE(1)) d1 (.clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_data(id1),
    .in_ready(ir1), .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(or1));
  rr_mux_arbiter #(.NUM_CH(3), .DATA_W(8), .MODE(0)) d2 (.clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_data(id2),
    .in_ready(ir2), .out_valid(ov2), .out_data(od2), .out_sel(os2), .out_ready(or2));
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", ov0); end
    checks++; if (od0 !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", od0); end
    checks++; if (os0 !== 2'd0) begin errors++; $display("FAIL rst_sel got %0d exp 0", os0); end
    iv0 = 4'b1111; or0 = 1'b1;
    #1;
    checks++; if (ir0 !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b exp 0000", ir0); end
    iv0 = '0;
    rst_n = 1'b1;
    step();
    step();
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", ov0); end
    checks++; if (ir0 !== 4'b0000) begin errors++; $display("FAIL idle_ready got %b exp 0000", ir0); end
  endtask
  task automatic test_single;
    iv0 = 4'b0100; id0 = 32'h00A5_0000; or0 = 1'b1;
    #1;
    checks++; if (ir0 !== 4'b0100) begin errors++; $display("FAIL single_ready got %b exp 0100", ir0); end
    step();
    iv0 = '0;
    checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", ov0); end
    checks++; if (od0 !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", od0); end
    checks++; if (os0 !== 2'd2) begin errors++; $display("FAIL single_sel got %0d exp 2", os0); end
    iv0 = 4'b1111;
    #1;
    checks++; if (ir0 !== 4'b1000) begin errors++; $display("FAIL single_ptr got %b exp 1000", ir0); end
    iv0 = '0;
    step();
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", ov0); end
  endtask
  task automatic test_mid_reset;
    iv0 = 4'b0001; id0 = 32'h0000_0055; or0 = 1'b0;
    step();
    iv0 = '0;
    checks++; if (ov0 !== 1'b1 || od0 !== 8'h55) begin errors++; $display("FAIL mid_load got %b/%h exp 1/55", ov0, od0); end
    rst_n = 1'b0;
    #1;
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", ov0); end
    checks++; if (od0 !== 8'h00) begin errors++; $display("FAIL mid_data got %h exp 00", od0); end
    checks++; if (os0 !== 2'd0) begin errors++; $display("FAIL mid_sel got %0d exp 0", os0); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (ov0 !== 1'b0 || ir0 !== 4'b0000) begin errors++; $display("FAIL mid_idle got %b/%b exp 0/0000", ov0, ir0); end
  endtask
  task automatic test_rr_fairness;
    iv0 = 4'b1111; id0 = 32'h1312_1110; or0 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++; if (ov0 !== 1'b1 || os0 !== 2'(k % 4) || od0 !== 8'(8'h10 + k % 4))
        begin errors++; $display("FAIL rr_%0d got v%b sel %0d data %h exp v1 sel %0d data %h", k, ov0, os0, od0, k % 4, 8'h10 + k % 4); end
    end
    iv0 = '0;
    step();
  endtask
  task automatic test_backpressure;
    iv0 = 4'b0100; id0 = 32'h003C_0000; or0 = 1'b1;
    step();
    or0 = 1'b0; iv0 = 4'b1011; id0 = 32'hA33C_A1A0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (ir0 !== 4'b0000) begin errors++; $display("FAIL bp_ready_%0d got %b exp 0000", k, ir0); end
      step();
      checks++; if (ov0 !== 1'b1 || od0 !== 8'h3C) begin errors++; $display("FAIL bp_hold_%0d got %b/%h exp 1/3c", k, ov0, od0); end
    end
    or0 = 1'b1;
    #1;
    checks++; if (ir0 !== 4'b1000) begin errors++; $display("FAIL bp_grant got %b exp 1000", ir0); end
    step();
    iv0 = '0;
    checks++; if (ov0 !== 1'b1 || od0 !== 8'hA3 || os0 !== 2'd3)
      begin errors++; $display("FAIL bp_reload got %b/%h/%0d exp 1/a3/3", ov0, od0, os0); end
    step();
  endtask
  task automatic test_fixed_priority;
    iv1 = 4'b1010; id1 = 32'h2300_2100; or1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (ir1 !== 4'b0010) begin errors++; $display("FAIL fp_ready_%0d got %b exp 0010", k, ir1); end
      step();
      checks++; if (os1 !== 2'd1 || od1 !== 8'h21) begin errors++; $display("FAIL fp_sel_%0d got %0d/%h exp 1/21", k, os1, od1); end
    end
    iv1 = 4'b1000;
    #1;
    checks++; if (ir1 !== 4'b1000) begin errors++; $display("FAIL fp_ch3_ready got %b exp 1000", ir1); end
    step();
    iv1 = '0;
    checks++; if (os1 !== 2'd3 || od1 !== 8'h23) begin errors++; $display("FAIL fp_ch3 got %0d/%h exp 3/23", os1, od1); end
  endtask
  task automatic test_npot_wrap;
    iv2 = 3'b101; id2 = 24'h32_31_30; or2 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++; if (ov2 !== 1'b1 || os2 !== ((k % 2) ? 2'd2 : 2'd0) || od2 !== ((k % 2) ? 8'h32 : 8'h30))
        begin errors++; $display("FAIL wrap_%0d got v%b sel %0d data %h exp sel %0d", k, ov2, os2, od2, (k % 2) ? 2 : 0); end
    end
    iv2 = '0;
    step();
  endtask
  initial begin
    step();
    step();
    test_reset();
    test_single();
    test_mid_reset();
    test_rr_fairness();
    test_backpressure();
    test_fixed_priority();
    test_npot_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
